// File: rtl/rgb_led_pkg.sv
// Shared types and constants for the RGB LED request scheduler.
package rgb_led_pkg;
    localparam int NREQ = 3;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    // Colors are {b,g,r}; a set bit means that LED is lit
    localparam logic [2:0] COLOR_OFF   = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b001;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b100;
    localparam logic [2:0] COLOR_WHITE = 3'b111;

    // Fixed priority: requester 0 wins
    function automatic logic [1:0] lowest_idx(input logic [NREQ-1:0] r);
        if (r[0])      return 2'd0;
        else if (r[1]) return 2'd1;
        else           return 2'd2;
    endfunction
endpackage

// File: rtl/rgb_led_tick.sv
// Tick prescaler: counts 0..TICK_DIV-1, o_tick is high on the terminal count.
module rgb_led_tick #(
    parameter int TICK_DIV = 2_400_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr || o_tick) r_cnt <= '0;
        else                          r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/rgb_led_sched.sv
// Fixed-priority scheduler sharing one RGB LED among three requesters.
// Define RGB_LED_SCHED_PREEMPT_EN to let a higher-priority request abort SHOW.
module rgb_led_sched
    import rgb_led_pkg::*;
#(
    parameter int TICK_DIV   = 2_400_000,
    parameter int HOLD_TICKS = 10
) (
    input  logic       clk_24m,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [8:0] req_color,
    input  logic [2:0] req_blink,
    output logic [2:0] grant,
    output logic       busy,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    state_t        r_state;
    logic [HW-1:0] r_hold;
    logic          r_phase;
    logic [2:0]    r_color;
    logic          r_blink;
    logic [2:0]    r_grant;
    logic          r_busy;
    logic [2:0]    r_led;

    logic       w_tick;
    logic       w_any;
    logic [1:0] w_win;
    logic [2:0] w_color;
    logic       w_blink;
    logic       w_take;
    logic       w_phase_n;

    assign w_any     = |req;
    assign w_win     = lowest_idx(req);
    assign w_blink   = req_blink[w_win];
    assign w_phase_n = r_blink ? ~r_phase : r_phase;

    always_comb begin
        w_color = req_color[2:0];
        case (w_win)
            2'd1:    w_color = req_color[5:3];
            2'd2:    w_color = req_color[8:6];
            default: w_color = req_color[2:0];
        endcase
    end

`ifdef RGB_LED_SCHED_PREEMPT_EN
    logic [1:0] r_owner;
    assign w_take = w_any && ((r_state == IDLE) ||
                              (r_state == SHOW && w_win < r_owner));
    always_ff @(posedge clk_24m) begin
        if (rst)         r_owner <= '0;
        else if (w_take) r_owner <= w_win;
    end
`else
    assign w_take = w_any && (r_state == IDLE);
`endif

    // A grant restarts the prescaler so SHOW gets whole ticks
    rgb_led_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk  (clk_24m),
        .i_rst  (rst),
        .i_clr  (w_take),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk_24m) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_phase <= 1'b0;
            r_color <= '0;
            r_blink <= 1'b0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_led   <= 3'b111;
        end else begin
            r_grant <= '0;
            if (w_take) begin
                r_state <= SHOW;
                r_color <= w_color;
                r_blink <= w_blink;
                r_phase <= 1'b1;
                r_hold  <= '0;
                r_grant <= 3'b001 << w_win;
                r_busy  <= 1'b1;
                r_led   <= ~w_color;
            end else begin
                case (r_state)
                    SHOW: if (w_tick) begin
                        if (r_hold == HW'(HOLD_TICKS - 1)) begin
                            r_state <= GAP;
                            r_led   <= 3'b111;
                        end else begin
                            r_hold  <= r_hold + 1'b1;
                            r_phase <= w_phase_n;
                            r_led   <= ~(r_color & {3{w_phase_n}});
                        end
                    end
                    GAP: if (w_tick) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;
    assign led_r = r_led[0];
    assign led_g = r_led[1];
    assign led_b = r_led[2];
endmodule

// File: tb/tb_rgb_led_sched.sv
// Bench for rgb_led_sched: directed scenarios plus random traffic against a
// transaction-level model (mode + elapsed cycles).
module tb_rgb_led_sched;
    localparam int TD       = 4;
    localparam int HT       = 3;
    localparam int SHOW_LEN = TD * HT;

    logic       clk_24m = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [8:0] req_color;
    logic [2:0] req_blink;
    logic [2:0] grant;
    logic       busy, led_r, led_g, led_b;

    rgb_led_sched #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
        .clk_24m   (clk_24m),
        .rst       (rst),
        .req       (req),
        .req_color (req_color),
        .req_blink (req_blink),
        .grant     (grant),
        .busy      (busy),
        .led_r     (led_r),
        .led_g     (led_g),
        .led_b     (led_b)
    );

    always #5 clk_24m = ~clk_24m;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model: mode 0 idle, 1 show, 2 gap; m_t = cycles elapsed in the mode
    int         m_mode = 0;
    int         m_t    = 0;
    int         m_owner = 0;
    logic [2:0] m_color = 3'b000;
    logic       m_blink = 1'b0;
    logic [2:0] m_grant = 3'b000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int low(input logic [2:0] r);
        for (int i = 0; i < 3; i++) if (r[i]) return i;
        return 3;
    endfunction

    task automatic step();
        bit         pre;
        int         w;
        logic       ph;
        logic [2:0] exp_led;
        @(posedge clk_24m);
        cyc++;
        m_grant = 3'b000;
        pre = 1'b0;
        if (rst) begin
            m_mode = 0;
        end else begin
`ifdef RGB_LED_SCHED_PREEMPT_EN
            if (m_mode == 1 && req != 3'b000 && low(req) < m_owner) pre = 1'b1;
`endif
            if ((m_mode == 0 && req != 3'b000) || pre) begin
                w       = low(req);
                m_mode  = 1;
                m_t     = 0;
                m_owner = w;
                m_color = req_color[3*w +: 3];
                m_blink = req_blink[w];
                m_grant = 3'(1 << w);
            end else if (m_mode == 1) begin
                m_t++;
                if (m_t == SHOW_LEN) begin m_mode = 2; m_t = 0; end
            end else if (m_mode == 2) begin
                m_t++;
                if (m_t == TD) m_mode = 0;
            end
        end
        #1;
        ph = m_blink ? ((m_t / TD) % 2 == 0) : 1'b1;
        exp_led = (m_mode == 1) ? ~(m_color & {3{ph}}) : 3'b111;
        chk("grant", grant, m_grant);
        chk("busy", busy, m_mode != 0);
        chk("leds", {led_b, led_g, led_r}, exp_led);
    endtask

    task automatic drain();
        req = 3'b000;
        rst = 1'b0;
        for (int i = 0; i < 40 && m_mode != 0; i++) step();
        chk("drain_idle", busy, 1'b0);
    endtask

    initial begin
        int n, prev;
        rst = 1'b1; req = 3'b111; req_color = 9'h1FF; req_blink = 3'b000;

        // reset held with all requests high
        repeat (2) begin
            step();
            chk("rst_grant", grant, 3'b000);
            chk("rst_leds", {led_b, led_g, led_r}, 3'b111);
        end
        rst = 1'b0;
        step();
        chk("first_grant", grant, 3'b001);
        drain();

        // steady red on requester 1
        req = 3'b110; req_color = 9'b000_001_000; req_blink = 3'b000;
        step();
        chk("g1", grant, 3'b010);
        chk("red_on", led_r, 1'b0);
        req = 3'b000;
        repeat (16) step();
        chk("busy_c17", busy, 1'b0);

        // blinking white on requester 2
        req = 3'b100; req_color = 9'b111_000_000; req_blink = 3'b100;
        step();
        req = 3'b000;
        repeat (16) step();

        // requester 0 arrives 3 cycles into requester 2's SHOW
        req = 3'b100; req_color = 9'b100_010_001; req_blink = 3'b000;
        step();
        req = 3'b000;
        repeat (2) step();
        req = 3'b001;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(); n++;
            if (grant == 3'b001) break;
        end
`ifdef RGB_LED_SCHED_PREEMPT_EN
        chk("preempt_lat", n, 1);
`else
        chk("wait_lat", n, 15);
`endif
        drain();

        // reset pulse mid-SHOW, requester 1 held
        req = 3'b010; req_color = 9'b000_011_000;
        step();
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("rst_mid_leds", {led_b, led_g, led_r}, 3'b111);
        chk("rst_mid_busy", busy, 1'b0);
        rst = 1'b0;
        step();
        chk("regrant", grant, 3'b010);
        drain();

        // requester 0 hogs the LED under fixed priority
        req = 3'b011; req_color = 9'b000_010_100;
        prev = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            chk("no_g1", grant[1], 1'b0);
            if (grant == 3'b001) begin
                if (prev >= 0) chk("period", cyc - prev, 17);
                prev = cyc;
            end
        end
        drain();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            req       = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            req_color = 9'($urandom);
            req_blink = 3'($urandom);
            rst       = ($urandom_range(0, 59) == 0);
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rgb_led_sched.md
RGB_LED_SCHED -- requirements
Module: rgb_led_sched

Interface
- REQ-001 The block SHALL have parameter `TICK_DIV`, default 2_400_000: clk_24m cycles per tick (100 ms); legal range >= 2.
- REQ-002 The block SHALL have parameter `HOLD_TICKS`, default 10: ticks a granted request owns the LED; legal range >= 1.
- REQ-003 The block SHALL have port `clk_24m`, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-004 The block SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
- REQ-005 The block SHALL have port `req`, input, 3 bits: one level request per requester; requester 0 is the highest priority.
- REQ-006 The block SHALL have port `req_color`, input, 9 bits: 3 bits {b,g,r} per requester; requester i uses bits [3i+2:3i]; color bit 1 = LED lit.
- REQ-007 The block SHALL have port `req_blink`, input, 3 bits: per requester, 1 = blink, 0 = steady.
- REQ-008 The block SHALL have port `grant`, output, 3 bits: one-hot, one-cycle pulse that acknowledges the request being serviced.
- REQ-009 The block SHALL have port `busy`, output, 1 bit: high in every state except IDLE.
- REQ-010 The block SHALL have ports `led_r`, `led_g`, `led_b`, outputs, 1 bit each: registered, active-low LED drives (0 = lit).

Function
- REQ-011 The FSM SHALL have exactly three states: IDLE, SHOW and GAP.
- REQ-012 IDLE: when any `req` bit is high at a clock edge, the block SHALL take the lowest-index requester as winner and, in the same edge:
  - latch the winner's color and blink bits;
  - set `grant` to the winner's one-hot for exactly one cycle;
  - clear the tick counter;
  - enter SHOW.
- REQ-013 Grant latency SHALL be 1 cycle: request sampled at edge N, `grant` and the lit LED visible after edge N.
- REQ-014 SHOW SHALL last exactly HOLD_TICKS*TICK_DIV cycles, then enter GAP.
- REQ-015 In SHOW the LED outputs SHALL be ~(latched color AND phase); phase is 1 at SHOW entry.
  - blink = 1: phase toggles at every tick boundary.
  - blink = 0: phase stays 1.
- REQ-016 GAP SHALL last exactly TICK_DIV cycles with all LEDs off (3'b111), then enter IDLE.
- REQ-017 A request SHALL NOT be sampled in SHOW or GAP, except as REQ-025 allows. A request that drops before being sampled is lost; there is no queueing.
- REQ-018 A requester whose `req` is still high on return to IDLE SHALL compete again. Priority is fixed, not round-robin.
- REQ-019 A color of 3'b000 SHALL still be granted and SHALL run the full SHOW/GAP sequence with the LED dark.
- REQ-020 The tick counter SHALL run 0..TICK_DIV-1 and wrap to 0. A tick boundary is the cycle in which the count equals TICK_DIV-1.

Reset
- REQ-021 While `rst` is high at a clock edge, the block SHALL force on that edge:
  - state = IDLE;
  - `grant` = 0 and `busy` = 0;
  - `led_r`, `led_g`, `led_b` = 1 (off);
  - the tick counter, hold counter, phase and latched color/blink = 0.
- REQ-022 Reset SHALL take precedence over every other event, including during SHOW or GAP and a grant in the same cycle. Requests seen during reset SHALL NOT be granted.
- REQ-023 After `rst` falls, the first edge with a `req` bit high SHALL grant it normally.

Configuration
- REQ-024 Macro `RGB_LED_SCHED_PREEMPT_EN` SHALL control preemption.
- REQ-025 With the macro defined: in SHOW, a high `req` bit with a lower index than the current owner SHALL abort SHOW at that edge and perform the REQ-012 grant for the new winner directly (no GAP). Preemption SHALL NOT happen in GAP.
- REQ-026 With the macro undefined: SHOW SHALL always run to completion.

Structure
- REQ-027 Package `rgb_led_pkg` SHALL hold:
  - the state enum {IDLE, SHOW, GAP};
  - the color constants COLOR_OFF/RED/GREEN/BLUE/WHITE in {b,g,r} order;
  - the requester count constant NREQ = 3.
- REQ-028 Sub-module `rgb_led_tick` SHALL hold the TICK_DIV prescaler, with a synchronous clear input and a one-cycle tick output; the FSM and arbiter stay in `rgb_led_sched`.

Verification (TICK_DIV=4, HOLD_TICKS=3: SHOW = 12 cycles, GAP = 4 cycles)
- REQ-029 `rst` high 2 cycles with req=3'b111 -> no grant; LEDs = 3'b111 and busy = 0 throughout; first grant after reset = 3'b001.
- REQ-030 req=3'b110, req_color[5:3]=3'b001 (red), steady -> grant=3'b010 one cycle later; led_r=0 for 12 cycles; LEDs off for 4 cycles; busy=0 on cycle 17.
- REQ-031 req[2] only, color 3'b111, blink=1 -> LEDs = 0,0,0 for 4 cycles, 1,1,1 for 4, 0,0,0 for 4, then GAP.
- REQ-032 req[2] granted, then req[0] raised 3 cycles into SHOW:
  - macro defined: grant=3'b001 on the next edge, no GAP;
  - macro undefined: grant=3'b001 on the cycle after GAP ends.
- REQ-033 `rst` pulsed for 1 cycle 5 cycles into SHOW -> LEDs off and state IDLE on the next cycle; a held req[1] is re-granted on the first edge after reset.
- REQ-034 req[0] held constantly high -> grant=3'b001 repeats exactly every 17 cycles (1 grant + 12 SHOW + 4 GAP); req[1] is never granted.
